cv_ctrl_scanner: RTL



---
 rtl/cv_ctrl_scanner_if.sv | 21 ++
 rtl/cv_ctrl_scanner.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cv_ctrl_scanner_if.sv
// ColecoVision controller port lines: selects p5/p8 driven by the console,
// p1-p4/p6 returned by the controller. Bit 0 = port A, bit 1 = port B.
interface cv_ctrl_scanner_if;
  logic [1:0] ctrl_p1_i;
  logic [1:0] ctrl_p2_i;
  logic [1:0] ctrl_p3_i;
  logic [1:0] ctrl_p4_i;
  logic [1:0] ctrl_p6_i;
  logic [1:0] ctrl_p5_o;
  logic [1:0] ctrl_p8_o;

  modport master (
    input  ctrl_p1_i, ctrl_p2_i, ctrl_p3_i, ctrl_p4_i, ctrl_p6_i,
    output ctrl_p5_o, ctrl_p8_o
  );

  modport slave (
    output ctrl_p1_i, ctrl_p2_i, ctrl_p3_i, ctrl_p4_i, ctrl_p6_i,
    input  ctrl_p5_o, ctrl_p8_o
  );
endinterface

// File: rtl/cv_ctrl_scanner.sv
// Console-side ColecoVision controller scanner: keypad/joystick select, decode, debounce.
// Optional macro CV_CTRL_SCAN_CHANGE_IRQ_EN adds per-port change_o pulses.
module cv_ctrl_scanner #(
  parameter int unsigned SETTLE      = 4,
  parameter int unsigned SCAN_PERIOD = 1024,
  parameter int unsigned DEBOUNCE    = 2
) (
  input  logic                  clk_sys,
  input  logic                  reset,
  input  logic                  ce,
  cv_ctrl_scanner_if.master     ctrl,
  output logic [7:0]            key_o,
  output logic [7:0]            dir_o,
  output logic [1:0]            fire1_o,
  output logic [1:0]            fire2_o,
  output logic                  scan_done_o
`ifdef CV_CTRL_SCAN_CHANGE_IRQ_EN
  ,
  output logic [1:0]            change_o
`endif
);

  localparam int unsigned PW = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
  localparam int unsigned SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(SCAN_PERIOD - 1);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE - 1);
  localparam logic [3:0]    DB          = 4'(DEBOUNCE);

  typedef enum logic [1:0] {S_IDLE, S_KEY, S_JOY, S_COMMIT} state_t;

  state_t          state;
  logic [PW-1:0]   period_cnt;
  logic [SW-1:0]   settle_cnt;
  logic [1:0]      p5_q;
  logic [1:0]      p8_q;

  logic [1:0][3:0] raw_key;
  logic [1:0][3:0] raw_dir;
  logic [1:0]      raw_f1;
  logic [1:0]      raw_f2;
  logic [1:0][9:0] prev;
  logic [1:0][3:0] cnt;

  logic [1:0][3:0] key_q;
  logic [1:0][3:0] dir_q;
  logic [1:0]      fire1_q;
  logic [1:0]      fire2_q;
  logic            done_q;

  logic [1:0][9:0] raw_vec;
  logic [1:0][3:0] cnt_nxt;
  logic [1:0]      publish;

  logic            period_wrap;
  logic            settle_hit;

  assign period_wrap = (period_cnt == PERIOD_LAST);
  assign settle_hit  = (settle_cnt == SETTLE_LAST);

  function automatic logic [3:0] decode(input logic [3:0] code);
    case (code)
      4'b0011: decode = 4'd0;
      4'b1110: decode = 4'd1;
      4'b1101: decode = 4'd2;
      4'b0110: decode = 4'd3;
      4'b0001: decode = 4'd4;
      4'b1001: decode = 4'd5;
      4'b0111: decode = 4'd6;
      4'b1100: decode = 4'd7;
      4'b1000: decode = 4'd8;
      4'b1011: decode = 4'd9;
      4'b1010: decode = 4'd10;
      4'b0101: decode = 4'd11;
      4'b0100: decode = 4'd12;
      4'b0010: decode = 4'd13;
      default: decode = 4'd15;
    endcase
  endfunction

  // Stable count is the post-update value; publishing keys off that new value.
  always_comb begin
    raw_vec = '0;
    cnt_nxt = '0;
    publish = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      raw_vec[p] = {raw_key[p], raw_dir[p], raw_f1[p], raw_f2[p]};
      if (raw_vec[p] == prev[p])
        cnt_nxt[p] = (cnt[p] >= DB) ? DB : cnt[p] + 4'd1;
      else
        cnt_nxt[p] = 4'd1;
      publish[p] = (cnt_nxt[p] == DB);
    end
  end

`ifdef CV_CTRL_SCAN_CHANGE_IRQ_EN
  logic [1:0] change_q;
  assign change_o = change_q;
`endif

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state       <= S_IDLE;
      period_cnt  <= '0;
      settle_cnt  <= '0;
      p5_q        <= '1;
      p8_q        <= '1;
      raw_key     <= '0;
      raw_dir     <= '0;
      raw_f1      <= '0;
      raw_f2      <= '0;
      prev        <= {2{4'hF, 6'b0}};
      cnt         <= '0;
      key_q       <= '1;
      dir_q       <= '0;
      fire1_q     <= '0;
      fire2_q     <= '0;
      done_q      <= 1'b0;
`ifdef CV_CTRL_SCAN_CHANGE_IRQ_EN
      change_q    <= '0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef CV_CTRL_SCAN_CHANGE_IRQ_EN
      change_q <= '0;
`endif
      if (ce)
        period_cnt <= period_wrap ? '0 : period_cnt + 1'b1;

      case (state)
        S_IDLE: begin
          p5_q <= '1;
          p8_q <= '1;
          if (ce && period_wrap) begin
            state      <= S_KEY;
            p5_q       <= 2'b00;
            settle_cnt <= '0;
          end
        end
        S_KEY: begin
          if (ce) begin
            if (settle_hit) begin
              for (int unsigned p = 0; p < 2; p++)
                raw_key[p] <= decode({ctrl.ctrl_p1_i[p], ctrl.ctrl_p2_i[p],
                                      ctrl.ctrl_p3_i[p], ctrl.ctrl_p4_i[p]});
              raw_f2     <= ~ctrl.ctrl_p6_i;
              state      <= S_JOY;
              p5_q       <= 2'b11;
              p8_q       <= 2'b00;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end
        S_JOY: begin
          if (ce) begin
            if (settle_hit) begin
              for (int unsigned p = 0; p < 2; p++)
                raw_dir[p] <= ~{ctrl.ctrl_p1_i[p], ctrl.ctrl_p2_i[p],
                                ctrl.ctrl_p3_i[p], ctrl.ctrl_p4_i[p]};
              raw_f1     <= ~ctrl.ctrl_p6_i;
              state      <= S_COMMIT;
              p8_q       <= 2'b11;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 1'b1;
            end
          end
        end
        S_COMMIT: begin
          done_q <= 1'b1;
          state  <= S_IDLE;
          for (int unsigned p = 0; p < 2; p++) begin
            cnt[p]  <= cnt_nxt[p];
            prev[p] <= raw_vec[p];
            if (publish[p]) begin
              key_q[p]   <= raw_key[p];
              dir_q[p]   <= raw_dir[p];
              fire1_q[p] <= raw_f1[p];
              fire2_q[p] <= raw_f2[p];
            end
`ifdef CV_CTRL_SCAN_CHANGE_IRQ_EN
            change_q[p] <= publish[p] &&
                           (raw_vec[p] != {key_q[p], dir_q[p], fire1_q[p], fire2_q[p]});
`endif
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign ctrl.ctrl_p5_o = p5_q;
  assign ctrl.ctrl_p8_o = p8_q;
  assign key_o          = key_q;
  assign dir_o          = dir_q;
  assign fire1_o        = fire1_q;
  assign fire2_o        = fire2_q;
  assign scan_done_o    = done_q;

endmodule
